accel_sample_filter: RTL and testbench
======================================

// Module: accel_sample_filter
// PURPOSE
//  Conditions raw accelerometer X/Y samples before they reach the CPU's player-position inputs.
//  Sits between AccelerometerCtl (upstream, same 50 MHz clock) and processor (downstream).
//  Per axis: samples at a fixed rate, then a 2^AVG_LOG2-tap moving average, calibration offset
//  removal, saturation and a deadzone. Emits a one-cycle valid strobe per new result.
// PARAMETERS
//  DATA_W     9      sample width, signed two's complement, both input and output
//  AVG_LOG2   3      log2 of moving-average depth (ring buffer of 8 samples per axis)
//  SAMPLE_DIV 50000  clock cycles per sample tick (1 kHz at 50 MHz); minimum 4
//  DEADZONE   4      |corrected value| <= DEADZONE is forced to 0
// PORTS
//  clock       in   1       system clock (50 MHz)
//  reset       in   1       asynchronous, active-low reset
//  enable      in   1       1 = sampling runs; 0 = freeze
//  accel_x_in  in   DATA_W  raw X sample, signed
//  accel_y_in  in   DATA_W  raw Y sample, signed
//  cal_req     in   1       pulse: capture current averages as the zero offsets
//  pos_x_out   out  DATA_W  filtered X, signed
//  pos_y_out   out  DATA_W  filtered Y, signed
//  data_valid  out  1       one-cycle pulse when pos_*_out update
//  cal_done    out  1       one-cycle pulse when the offsets are loaded
// BEHAVIOUR
//  Reset (reset=0, async): tick counter, ring buffers, sums, offsets, fill count and all outputs
//   clear to 0. State goes to FILL. Reset applied mid-operation behaves exactly like power-up.
//  Tick: counter runs 0..SAMPLE_DIV-1 while enable=1. tick=1 when count==SAMPLE_DIV-1; count then
//   wraps to 0. enable=0 holds the counter, state, buffers and outputs, and data_valid=0.
//  On tick (edge E), per axis:
//   - buffer[wr_ptr] <= input.
//   - sum <= sum + input - buffer[wr_ptr].
//   - wr_ptr increments and wraps modulo 2^AVG_LOG2.
//   - sum is signed, DATA_W+AVG_LOG2 bits wide and never overflows.
//  Result path (registered at edge E+1):
//   - avg  = sum >>> AVG_LOG2 (arithmetic shift, floor).
//   - corr = avg - offset, computed DATA_W+1 bits wide, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   - out  = (|corr| <= DEADZONE) ? 0 : corr.
//   - In RUN, pos_*_out <= out and data_valid=1 for exactly the cycle after edge E+1.
//  FSM:
//   FILL: ticks update buffers and sums; outputs held at 0; data_valid never asserted.
//     After the 2^AVG_LOG2-th tick's sum update, go to RUN.
//   RUN: normal operation as above.
//     cal_req=1 (or pending flag set) -> CAL.
//   CAL: offset_x/y <= current avg_x/y. cal_done=1 for one cycle, then RUN. Lasts one cycle.
//     A tick coinciding with CAL is processed normally; the offset uses the pre-tick average.
//  cal_req in FILL sets a pending flag. The flag is serviced on entry to RUN and cleared in CAL.
//   cal_req while already in CAL is ignored.
//  cal_req and a result update in the same cycle: the result uses the old offset.
//   The next result uses the new offset.
//  Outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING (bench: SAMPLE_DIV=4, AVG_LOG2=2, DEADZONE=4)
//  1. Release reset; hold x=20, y=-12. No data_valid during the first 4 ticks. Then
//     data_valid every 4 cycles with pos_x_out=20, pos_y_out=-12.
//  2. After FILL, steady x=3 -> pos_x_out=0. Steady x=-5 -> -5. Steady x=4 -> 0.
//  3. After FILL at x=0, step to x=40 -> successive valid outputs 10, 20, 30, 40, 40.
//  4. Steady x=100; pulse cal_req -> cal_done 1 cycle later and the next output is 0.
//     Step to x=120 -> outputs 5, 10, 15, 20.
//  5. Steady x=-256; calibrate; step to x=255 -> corr overflows the range; saturates at 255 once
//     the average exceeds offset+255.
//  6. In RUN: assert reset for 3 cycles -> outputs, valid and offsets read 0 immediately.
//     After release, 4 ticks of FILL with no valid. cal_req issued during FILL is honoured on
//     entering RUN; drop enable for 20 cycles -> no valid, outputs frozen.

Source files
------------

// File: rtl/accel_sample_filter.sv
// Accelerometer conditioner: fixed-rate sampling, moving average, calibration
// offset, saturation and deadzone ahead of the CPU's player-position inputs.
module accel_sample_filter #(
    parameter int DATA_W     = 9,
    parameter int AVG_LOG2   = 3,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEADZONE   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] accel_x_in,
    input  logic signed [DATA_W-1:0] accel_y_in,
    input  logic                     cal_req,
    output logic signed [DATA_W-1:0] pos_x_out,
    output logic signed [DATA_W-1:0] pos_y_out,
    output logic                     data_valid,
    output logic                     cal_done
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic signed [DATA_W:0] C_MAX =
        (DATA_W+1)'((2 ** (DATA_W-1)) - 1);
    localparam logic signed [DATA_W:0] C_MIN =
        (DATA_W+1)'(-(2 ** (DATA_W-1)));
    localparam logic signed [DATA_W:0] DZ_P = (DATA_W+1)'(DEADZONE);
    localparam logic signed [DATA_W:0] DZ_N = (DATA_W+1)'(-DEADZONE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [AVG_LOG2-1:0] PTR_LAST = AVG_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, RUN, CAL} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     tick;
    logic                     tick_d;
    logic                     cal_pend;
    logic [AVG_LOG2-1:0]      wr_ptr;
    logic signed [DATA_W-1:0] ring   [2][DEPTH];
    logic signed [SUM_W-1:0]  sum    [2];
    logic signed [DATA_W-1:0] offset [2];
    logic signed [DATA_W-1:0] sample [2];
    logic signed [DATA_W-1:0] avg    [2];
    logic signed [DATA_W-1:0] res    [2];
    logic signed [DATA_W-1:0] pos    [2];
    logic signed [DATA_W:0]   corr   [2];

    assign tick      = enable && (cnt == CNT_LAST);
    assign sample[0] = accel_x_in;
    assign sample[1] = accel_y_in;
    assign pos_x_out = pos[0];
    assign pos_y_out = pos[1];

    // Deadzone is judged on the unsaturated difference.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            avg[a]  = DATA_W'(sum[a] >>> AVG_LOG2);
            corr[a] = (DATA_W+1)'(avg[a]) - (DATA_W+1)'(offset[a]);
            if (corr[a] > C_MAX)
                res[a] = C_MAX[DATA_W-1:0];
            else if (corr[a] < C_MIN)
                res[a] = C_MIN[DATA_W-1:0];
            else
                res[a] = corr[a][DATA_W-1:0];
            if (corr[a] >= DZ_N && corr[a] <= DZ_P)
                res[a] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            cnt        <= '0;
            tick_d     <= 1'b0;
            cal_pend   <= 1'b0;
            wr_ptr     <= '0;
            data_valid <= 1'b0;
            cal_done   <= 1'b0;
            for (int a = 0; a < 2; a++) begin
                sum[a]    <= '0;
                offset[a] <= '0;
                pos[a]    <= '0;
                for (int i = 0; i < DEPTH; i++)
                    ring[a][i] <= '0;
            end
        end else begin
            data_valid <= 1'b0;
            cal_done   <= 1'b0;
            if (enable) begin
                cnt    <= tick ? '0 : cnt + 1'b1;
                tick_d <= tick && (state != FILL);
                if (tick) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    for (int a = 0; a < 2; a++) begin
                        ring[a][wr_ptr] <= sample[a];
                        sum[a] <= sum[a] + SUM_W'(sample[a])
                                  - SUM_W'(ring[a][wr_ptr]);
                    end
                end
                if (tick_d) begin
                    pos[0]     <= res[0];
                    pos[1]     <= res[1];
                    data_valid <= 1'b1;
                end
                unique case (state)
                    FILL: begin
                        if (cal_req)
                            cal_pend <= 1'b1;
                        if (tick && wr_ptr == PTR_LAST)
                            state <= RUN;
                    end
                    RUN: begin
                        if (cal_req || cal_pend)
                            state <= CAL;
                    end
                    CAL: begin
                        offset[0] <= avg[0];
                        offset[1] <= avg[1];
                        cal_done  <= 1'b1;
                        cal_pend  <= 1'b0;
                        state     <= RUN;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_accel_sample_filter.sv
// Bench for accel_sample_filter: directed scenarios plus random traffic,
// each cycle compared against a queue-based reference model.
module tb_accel_sample_filter;
    localparam int W     = 9;
    localparam int LG    = 2;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int DZ    = 4;
    localparam int OMAX  = 255;
    localparam int OMIN  = -256;
    localparam int M_FILL = 0;
    localparam int M_RUN  = 1;
    localparam int M_CAL  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic cal_req = 1'b0;
    logic signed [W-1:0] accel_x_in = '0;
    logic signed [W-1:0] accel_y_in = '0;
    logic signed [W-1:0] pos_x_out;
    logic signed [W-1:0] pos_y_out;
    logic data_valid;
    logic cal_done;

    int n_cmp = 0;
    int n_bad = 0;
    int xv, yv;
    int seen_valid, seen_done;

    int m_cnt, m_ticks, m_mode, m_off_x, m_off_y;
    bit m_due, m_pend;
    int hx[$];
    int hy[$];
    int e_px, e_py;
    bit e_val, e_done;

    always #5 clock = ~clock;

    accel_sample_filter #(
        .DATA_W(W), .AVG_LOG2(LG), .SAMPLE_DIV(DIV), .DEADZONE(DZ)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .accel_x_in(accel_x_in), .accel_y_in(accel_y_in),
        .cal_req(cal_req), .pos_x_out(pos_x_out), .pos_y_out(pos_y_out),
        .data_valid(data_valid), .cal_done(cal_done)
    );

    function automatic int floor_avg(int s);
        int q = s / DEPTH;
        if (s % DEPTH != 0 && s < 0) q--;
        return q;
    endfunction

    function automatic int shape(int a, int off);
        int c = a - off;
        if (c > OMAX) c = OMAX;
        if (c < OMIN) c = OMIN;
        if (c >= -DZ && c <= DZ) c = 0;
        return c;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_ticks = 0; m_mode = M_FILL;
        m_off_x = 0; m_off_y = 0; m_due = 0; m_pend = 0;
        hx.delete(); hy.delete();
        e_px = 0; e_py = 0; e_val = 0; e_done = 0;
    endtask

    // Expected outputs after the coming clock edge.
    task automatic m_step(bit en, int x, int y, bit cr);
        int sx = 0;
        int sy = 0;
        int ax, ay, mode_n;
        bit tk;
        e_val = 0;
        e_done = 0;
        if (!en) return;
        foreach (hx[i]) sx += hx[i];
        foreach (hy[i]) sy += hy[i];
        ax = floor_avg(sx);
        ay = floor_avg(sy);
        tk = (m_cnt == DIV - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (m_due) begin
            e_px = shape(ax, m_off_x);
            e_py = shape(ay, m_off_y);
            e_val = 1;
        end
        m_due = tk && (m_mode != M_FILL);
        mode_n = m_mode;
        case (m_mode)
            M_FILL: begin
                if (cr) m_pend = 1;
                if (tk && m_ticks + 1 == DEPTH) mode_n = M_RUN;
            end
            M_RUN: if (cr || m_pend) mode_n = M_CAL;
            default: begin
                m_off_x = ax; m_off_y = ay;
                e_done = 1; m_pend = 0; mode_n = M_RUN;
            end
        endcase
        m_mode = mode_n;
        if (tk) begin
            hx.push_back(x);
            hy.push_back(y);
            if (hx.size() > DEPTH) void'(hx.pop_front());
            if (hy.size() > DEPTH) void'(hy.pop_front());
            m_ticks++;
        end
    endtask

    task automatic check_all(string tag);
        n_cmp++;
        assert (pos_x_out === W'(e_px)) else begin
            n_bad++;
            $error("FAIL %s pos_x got %0d want %0d", tag, pos_x_out, e_px);
        end
        n_cmp++;
        assert (pos_y_out === W'(e_py)) else begin
            n_bad++;
            $error("FAIL %s pos_y got %0d want %0d", tag, pos_y_out, e_py);
        end
        n_cmp++;
        assert (data_valid === e_val) else begin
            n_bad++;
            $error("FAIL %s valid got %b want %b", tag, data_valid, e_val);
        end
        n_cmp++;
        assert (cal_done === e_done) else begin
            n_bad++;
            $error("FAIL %s cal_done got %b want %b", tag, cal_done, e_done);
        end
    endtask

    task automatic expect_int(string tag, int got, int want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic set_xy(int x, int y);
        xv = x;
        yv = y;
        accel_x_in = W'(x);
        accel_y_in = W'(y);
    endtask

    task automatic run_cycle(string tag);
        m_step(enable, xv, yv, cal_req);
        @(posedge clock);
        #1;
        check_all(tag);
        if (data_valid === 1'b1) seen_valid++;
        if (cal_done === 1'b1) seen_done++;
    endtask

    task automatic run_n(int n, string tag);
        for (int i = 0; i < n; i++) run_cycle(tag);
    endtask

    task automatic next_valid(string tag, output int px, output int py,
                              output int cyc);
        cyc = 0;
        do begin
            run_cycle(tag);
            cyc++;
        end while (data_valid !== 1'b1 && cyc < 16);
        expect_int({tag, "_timeout"}, int'(data_valid === 1'b1), 1);
        px = pos_x_out;
        py = pos_y_out;
    endtask

    task automatic calibrate(string tag);
        cal_req = 1'b1;
        run_cycle(tag);
        cal_req = 1'b0;
        run_cycle(tag);
        expect_int({tag, "_cal_done"}, int'(cal_done === 1'b1), 1);
    endtask

    int px, py, cyc;
    int ramp_a[5];
    int ramp_b[4];
    int sat_c[5];

    initial begin
        ramp_a = '{10, 20, 30, 40, 40};
        ramp_b = '{5, 10, 15, 20};
        sat_c  = '{127, 255, 255, 255, 255};
        m_reset();
        set_xy(0, 0);
        #12;
        check_all("reset");

        reset = 1'b1;
        enable = 1'b1;
        set_xy(20, -12);
        seen_valid = 0;
        run_n(16, "fill1");
        expect_int("fill1_no_valid", seen_valid, 0);
        next_valid("t1a", px, py, cyc);
        expect_int("t1_x", px, 20);
        expect_int("t1_y", py, -12);
        next_valid("t1b", px, py, cyc);
        expect_int("t1_period", cyc, 4);

        set_xy(3, 0);
        run_n(20, "t2a");
        next_valid("t2a", px, py, cyc);
        expect_int("t2_x3", px, 0);
        set_xy(-5, 0);
        run_n(20, "t2b");
        next_valid("t2b", px, py, cyc);
        expect_int("t2_xm5", px, -5);
        set_xy(4, 0);
        run_n(20, "t2c");
        next_valid("t2c", px, py, cyc);
        expect_int("t2_x4", px, 0);

        set_xy(0, 0);
        run_n(20, "t3");
        next_valid("t3", px, py, cyc);
        set_xy(40, 0);
        for (int i = 0; i < 5; i++) begin
            next_valid("t3r", px, py, cyc);
            expect_int("t3_ramp", px, ramp_a[i]);
        end

        set_xy(100, 0);
        run_n(20, "t4");
        next_valid("t4", px, py, cyc);
        calibrate("t4");
        next_valid("t4c", px, py, cyc);
        expect_int("t4_zero", px, 0);
        set_xy(120, 0);
        for (int i = 0; i < 4; i++) begin
            next_valid("t4r", px, py, cyc);
            expect_int("t4_ramp", px, ramp_b[i]);
        end

        set_xy(-256, 0);
        run_n(20, "t5");
        next_valid("t5", px, py, cyc);
        calibrate("t5");
        next_valid("t5c", px, py, cyc);
        expect_int("t5_zero", px, 0);
        set_xy(255, 0);
        for (int i = 0; i < 5; i++) begin
            next_valid("t5s", px, py, cyc);
            expect_int("t5_sat", px, sat_c[i]);
        end

        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check_all("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_all("rst_hold");
        end
        reset = 1'b1;
        set_xy(30, 10);
        seen_valid = 0;
        seen_done = 0;
        run_n(6, "t6f");
        cal_req = 1'b1;
        run_cycle("t6f");
        cal_req = 1'b0;
        run_n(9, "t6f");
        expect_int("t6_fill_no_valid", seen_valid, 0);
        run_n(8, "t6p");
        expect_int("t6_pending_cal", seen_done, 1);
        next_valid("t6v", px, py, cyc);
        expect_int("t6_x", px, 0);
        expect_int("t6_y", py, 0);
        enable = 1'b0;
        seen_valid = 0;
        run_n(20, "t6_frozen");
        expect_int("t6_frozen_valid", seen_valid, 0);
        enable = 1'b1;

        for (int s = 0; s < 60; s++) begin
            int hold;
            if ($urandom_range(2) == 0)
                set_xy(int'($urandom_range(12)) - 6,
                       int'($urandom_range(12)) - 6);
            else
                set_xy(int'($urandom_range(511)) - 256,
                       int'($urandom_range(511)) - 256);
            hold = int'($urandom_range(12)) + 1;
            for (int i = 0; i < hold; i++) begin
                cal_req = ($urandom_range(39) == 0);
                enable  = ($urandom_range(9) != 0);
                run_cycle("rand");
            end
        end
        cal_req = 1'b0;
        enable = 1'b1;
        run_n(8, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
